// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared sizes, state encoding, saturation limits and lane helper for psum_accum_buf
package psum_pkg;

    localparam int PSUM_LANES = 4;
    localparam int PSUM_DW    = 16;
    localparam int PSUM_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } psum_state_e;

    localparam logic signed [PSUM_DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [PSUM_DW-1:0] SAT_MIN = 16'sh8000;

    // Lane 0 sits in the most significant bits of the packed word.
    function automatic logic [PSUM_DW-1:0] lane_slice(
        input logic [PSUM_LANES*PSUM_DW-1:0] word,
        input int                            lane
    );
        return word[(PSUM_LANES-1-lane)*PSUM_DW +: PSUM_DW];
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// rtl/psum_sat_add.sv - one-lane signed saturating adder; passes b through when add_en is low
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int DW = PSUM_DW
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic                 add_en,
    output logic signed [DW-1:0] sum
);

    logic [DW:0] wide;

    assign wide = {a[DW-1], a} + {b[DW-1], b};

    // Overflow shows up as disagreement between the two top bits of the widened sum.
    always_comb begin
        sum = b;
        if (add_en) begin
            if (wide[DW] != wide[DW-1]) begin
                sum = wide[DW] ? SAT_MIN : SAT_MAX;
            end else begin
                sum = wide[DW-1:0];
            end
        end
    end

endmodule

// File: rtl/psum_accum_buf.sv
// rtl/psum_accum_buf.sv - multi-pass saturating partial-sum accumulator with ReLU drain
module psum_accum_buf
    import psum_pkg::*;
#(
    parameter int LANES  = PSUM_LANES,
    parameter int DW     = PSUM_DW,
    parameter int DEPTH  = PSUM_DEPTH,
    parameter int LEN_W  = 5,
    parameter int PASS_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [PASS_W-1:0]     cfg_num_pass,
    input  logic                  cfg_relu,
    input  logic [LANES*DW-1:0]   psum_pkd_in,
    input  logic                  psum_vld,
    output logic                  psum_rdy,
    output logic [LANES*DW-1:0]   out_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = LANES * DW;

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ACCUM = ST_ACCUM;
    localparam logic [1:0] DRAIN = ST_DRAIN;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]        state;
    logic [WW-1:0]     buf_mem [DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  wr_ptr;
    logic [LEN_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  next_rd;
    logic [LEN_W-1:0]  drain_idx;
    logic [PASS_W-1:0] num_pass_q;
    logic [PASS_W-1:0] pass_cnt;
    logic              relu_q;

    logic [WW-1:0]     cur_word;
    logic [WW-1:0]     acc_word;
    logic              accept;
    logic              last_word;
    logic              last_pass;
    logic              last_rd;
    logic              cfg_ok;

    assign psum_rdy  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign accept    = psum_vld & psum_rdy;
    assign last_word = (wr_ptr == len_q - LEN_W'(1));
    assign last_pass = (pass_cnt == num_pass_q - PASS_W'(1));
    assign last_rd   = (rd_ptr == len_q - LEN_W'(1));
    assign cfg_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
    assign next_rd   = rd_ptr + LEN_W'(1);
    // The first load of a drain presents rd_ptr itself; later loads follow a handshake.
    assign drain_idx = out_vld ? next_rd : rd_ptr;
    assign cur_word  = buf_mem[wr_ptr[AW-1:0]];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        psum_sat_add #(.DW(DW)) u_sat (
            .a      (lane_slice(cur_word, l)),
            .b      (lane_slice(psum_pkd_in, l)),
            .add_en (pass_cnt != '0),
            .sum    (acc_word[(LANES-1-l)*DW +: DW])
        );
    end

    function automatic logic [WW-1:0] relu_word(input logic [WW-1:0] w, input logic en);
        logic [WW-1:0] res;
        res = w;
        for (int l = 0; l < LANES; l++) begin
            if (en && w[(LANES-1-l)*DW + DW-1]) begin
                res[(LANES-1-l)*DW +: DW] = '0;
            end
        end
        return res;
    endfunction

    // Buffer contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            buf_mem[wr_ptr[AW-1:0]] <= acc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pass_cnt   <= '0;
            len_q      <= '0;
            num_pass_q <= '0;
            relu_q     <= 1'b0;
            out_vld    <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        len_q      <= cfg_len;
                        num_pass_q <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
                        relu_q     <= cfg_relu;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        pass_cnt   <= '0;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (last_word) begin
                            wr_ptr <= '0;
                            if (last_pass) begin
                                pass_cnt <= '0;
                                rd_ptr   <= '0;
                                state    <= DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + PASS_W'(1);
                            end
                        end else begin
                            wr_ptr <= wr_ptr + LEN_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!out_vld) begin
                        out_data <= relu_word(buf_mem[drain_idx[AW-1:0]], relu_q);
                        out_vld  <= 1'b1;
                    end else if (out_rdy) begin
                        if (last_rd) begin
                            out_vld <= 1'b0;
                            state   <= DONE;
                        end else begin
                            rd_ptr   <= next_rd;
                            out_data <= relu_word(buf_mem[drain_idx[AW-1:0]], relu_q);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_buf.sv
// tb/tb_psum_accum_buf.sv - directed self-checking bench for psum_accum_buf
module tb_psum_accum_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  cfg_len;
    logic [3:0]  cfg_num_pass;
    logic        cfg_relu;
    logic [63:0] psum_pkd_in;
    logic        psum_vld;
    logic        psum_rdy;
    logic [63:0] out_data;
    logic        out_vld;
    logic        out_rdy;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    logic [63:0] eq [$];
    logic [63:0] bp [4];

    psum_accum_buf dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_num_pass (cfg_num_pass),
        .cfg_relu     (cfg_relu),
        .psum_pkd_in  (psum_pkd_in),
        .psum_vld     (psum_vld),
        .psum_rdy     (psum_rdy),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic start_tile(input logic [4:0] len, input logic [3:0] np, input logic relu);
        cfg_len      = len;
        cfg_num_pass = np;
        cfg_relu     = relu;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic send(input logic [63:0] w);
        int n;
        psum_pkd_in = w;
        psum_vld    = 1'b1;
        n = 0;
        while (!psum_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!psum_rdy) chk("psum_rdy_timeout", psum_rdy, 1);
        tick();
        psum_vld = 1'b0;
    endtask

    // Drains eq with out_rdy held high; leaves the bench in the DONE cycle.
    task automatic drain_check(input string tag);
        int n;
        out_rdy = 1'b1;
        for (int i = 0; i < eq.size(); i++) begin
            n = 0;
            while (!out_vld && n < 10) begin
                tick();
                n++;
            end
            chk({tag, "_vld"}, out_vld, 1);
            chk({tag, "_data"}, out_data, eq[i]);
            tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_vld_low"}, out_vld, 0);
    endtask

    initial begin
        int idx;
        bit hs;
        logic [15:0] a;

        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_num_pass = '0; cfg_relu = 1'b0;
        psum_pkd_in = '0; psum_vld = 1'b0; out_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_psum_rdy", psum_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Single pass, with latency and DONE-cycle start checks
        out_rdy = 1'b1;
        start_tile(5'd2, 4'd1, 1'b0);
        chk("t1_busy", busy, 1);
        chk("t1_rdy", psum_rdy, 1);
        send(64'h0001_0002_0003_0004);
        send(64'hFFFF_0000_0010_7FFF);
        chk("t1_rdy_drop", psum_rdy, 0);
        chk("t1_vld_not_yet", out_vld, 0);
        tick();
        chk("t1_vld_latency", out_vld, 1);
        eq.delete();
        eq.push_back(64'h0001_0002_0003_0004);
        eq.push_back(64'hFFFF_0000_0010_7FFF);
        drain_check("t1");
        cfg_len = 5'd1; cfg_num_pass = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_start_in_done", busy, 0);
        tick();
        chk("t1_still_idle", busy, 0);
        chk("t1_done_once", done_cnt, 1);

        // Three-pass accumulate
        start_tile(5'd1, 4'd3, 1'b0);
        repeat (3) send(64'h0005_FFFE_0100_0000);
        eq.delete();
        eq.push_back(64'h000F_FFFA_0300_0000);
        drain_check("t2");
        tick();

        // Saturation both directions
        start_tile(5'd1, 4'd2, 1'b0);
        send(64'h7FF0_8010_0000_0000);
        send(64'h0020_FFE0_0000_0000);
        eq.delete();
        eq.push_back(64'h7FFF_8000_0000_0000);
        drain_check("t3");
        tick();

        // Sticky saturation: 7FF0 + 0020 clamps to 7FFF, then - 16 gives 7FEF
        start_tile(5'd1, 4'd3, 1'b0);
        send(64'h7FF0_0000_0000_0000);
        send(64'h0020_0000_0000_0000);
        send(64'hFFF0_0000_0000_0000);
        eq.delete();
        eq.push_back(64'h7FEF_0000_0000_0000);
        drain_check("t3b");
        tick();

        // ReLU with cfg_num_pass=0 treated as one pass
        start_tile(5'd1, 4'd0, 1'b1);
        send(64'hFFFF_8000_0001_0000);
        eq.delete();
        eq.push_back(64'h0000_0000_0001_0000);
        drain_check("t4");
        tick();
        chk("t4_idle", busy, 0);

        // Backpressure with out_rdy pattern 1,0,0,1,0,0...
        for (int i = 0; i < 4; i++) bp[i] = 64'h1000_2000_3000_4000 + 64'(i) * 64'h0001_0001_0001_0001;
        out_rdy = 1'b0;
        start_tile(5'd4, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) send(bp[i]);
        idx = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            out_rdy = (c % 3 == 0);
            if (out_vld) chk("t5_data", out_data, bp[idx]);
            hs = out_vld && out_rdy;
            tick();
            if (hs) idx++;
        end
        chk("t5_handshakes", idx, 4);
        chk("t5_done", done, 1);
        out_rdy = 1'b1;
        tick();
        chk("t5_done_count", done_cnt, 6);

        // Abort mid-ACCUM
        start_tile(5'd4, 4'd1, 1'b0);
        send(64'h1111_1111_1111_1111);
        send(64'h2222_2222_2222_2222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rdy", psum_rdy, 0);
        chk("t6_vld", out_vld, 0);
        chk("t6_data", out_data, 64'h0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        tick();
        chk("t6_no_done_pulse", done_cnt, 6);

        // Illegal length start is ignored
        start_tile(5'd0, 4'd1, 1'b0);
        chk("t6_len0_busy", busy, 0);
        chk("t6_len0_rdy", psum_rdy, 0);

        // Full-depth tile, two passes; cfg changes and a start while busy must not matter
        start_tile(5'd16, 4'd2, 1'b0);
        cfg_len = 5'd3;
        cfg_num_pass = 4'd1;
        start = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 16; i++) begin
                a = 16'(i);
                send({a, 16'h0 - a, 16'(100 * i), 16'h0101});
                start = 1'b0;
            end
        end
        eq.delete();
        for (int i = 0; i < 16; i++) begin
            a = 16'(2 * i);
            eq.push_back({a, 16'h0 - a, 16'(200 * i), 16'h0202});
        end
        drain_check("t7");
        tick();
        chk("t7_idle", busy, 0);
        chk("t7_done_count", done_cnt, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
